// File: rtl/key_debounce_onehot.sv
// rtl/key_debounce_onehot.sv - synchronizes and debounces 10 key lines into a registered one-hot vector and press strobe
// Optional macro KEY_MULTI_ERR_EN adds the registered oERR multi-key flag.
module key_debounce_onehot #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iKEY,
    output logic [9:0] oKEY,
    output logic       oPRESS
`ifdef KEY_MULTI_ERR_EN
    ,
    output logic       oERR
`endif
);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} stateT;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    stateT            state;
    stateT            nextState;
    logic [9:0]       syncMeta;
    logic [9:0]       keySync;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [9:0]       cand;
    logic [9:0]       candNext;
    logic [9:0]       keyNext;
    logic             pressNext;
    logic             isOneHot;

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign isOneHot = (keySync != 10'd0) && ((keySync & (keySync - 10'd1)) == 10'd0);

    always_comb begin
        nextState = state;
        cntNext   = cnt;
        candNext  = cand;
        keyNext   = oKEY;
        pressNext = 1'b0;
        case (state)
            IDLE: begin
                keyNext = 10'd0;
                if (isOneHot) begin
                    candNext  = keySync;
                    cntNext   = '0;
                    nextState = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (keySync != cand) begin
                    nextState = IDLE;
                end else if (cnt == CNT_LAST) begin
                    nextState = HELD;
                    keyNext   = cand;
                    pressNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                keyNext = cand;
                if (keySync != cand) begin
                    cntNext   = '0;
                    nextState = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                // Any non-matching vector counts toward release, even if it keeps changing.
                if (keySync == cand) begin
                    nextState = HELD;
                end else if (cnt == CNT_LAST) begin
                    nextState = IDLE;
                    keyNext   = 10'd0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: begin
                nextState = IDLE;
                keyNext   = 10'd0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            syncMeta <= 10'd0;
            keySync  <= 10'd0;
            cnt      <= '0;
            cand     <= 10'd0;
            oKEY     <= 10'd0;
            oPRESS   <= 1'b0;
        end else begin
            syncMeta <= iKEY;
            keySync  <= syncMeta;
            cnt      <= cntNext;
            cand     <= candNext;
            oKEY     <= keyNext;
            oPRESS   <= pressNext;
        end
    end

`ifdef KEY_MULTI_ERR_EN
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oERR <= 1'b0;
        end else begin
            oERR <= ((keySync & (keySync - 10'd1)) != 10'd0);
        end
    end
`endif

endmodule

// File: tb/tb_key_debounce_onehot.sv
// tb/tb_key_debounce_onehot.sv - scoreboard bench for key_debounce_onehot with a run-length reference model
module tb_key_debounce_onehot;

    localparam int DB = 4;

    typedef struct packed {
        logic [9:0] key;
        logic       press;
    } expT;

    logic       clk = 1'b0;
    logic       iRST;
    logic [9:0] iKEY;
    logic [9:0] oKEY;
    logic       oPRESS;
`ifdef KEY_MULTI_ERR_EN
    logic       oERR;
`endif

    expT expQ[$];
    int  checkCount = 0;
    int  passCount  = 0;
    logic [9:0] lastOneHot = 10'h001;

    always #5 clk = ~clk;

    key_debounce_onehot #(.DB_CYCLES(DB), .CNT_W(16)) dut (
        .iCLK   (clk),
        .iRST   (iRST),
        .iKEY   (iKEY),
        .oKEY   (oKEY),
        .oPRESS (oPRESS)
`ifdef KEY_MULTI_ERR_EN
        ,
        .oERR   (oERR)
`endif
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: the key seen two edges late must repeat for DB+1 consecutive samples
    // (first one seen while idle) to be accepted; releases likewise need DB+1 mismatching samples.
    initial begin
        logic [9:0] sp1, sp2, s, acc, pend;
        int         run, rel;
        logic       press;
        sp1 = 0; sp2 = 0; acc = 0; pend = 0; run = 0; rel = 0;
        forever begin
            @(posedge clk);
            press = 1'b0;
            if (iRST) begin
                sp1 = 0; sp2 = 0; acc = 0; pend = 0; run = 0; rel = 0;
            end else begin
                s = sp2;
                if (acc == 10'd0) begin
                    if (run > 0) begin
                        if (s == pend) begin
                            run++;
                            if (run == DB + 1) begin
                                acc = pend; run = 0; press = 1'b1;
                            end
                        end else begin
                            run = 0;
                        end
                    end else if ($countones(s) == 1) begin
                        pend = s; run = 1;
                    end
                end else begin
                    if (rel > 0) begin
                        if (s == acc) rel = 0;
                        else begin
                            rel++;
                            if (rel == DB + 1) begin
                                acc = 0; rel = 0;
                            end
                        end
                    end else if (s != acc) begin
                        rel = 1;
                    end
                end
                sp2 = sp1;
                sp1 = iKEY;
            end
            expQ.push_back('{key: acc, press: press});
        end
    end

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("oKEY", oKEY, e.key);
                check("oPRESS", {9'd0, oPRESS}, {9'd0, e.press});
                check("oKEY_onehot_or_zero", {9'd0, ($countones(oKEY) <= 1)}, 10'd1);
            end
        end
    end

    task automatic hold(input logic [9:0] v, input int n);
        iKEY = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        iRST = 1'b1;
        @(posedge clk);
        #1;
        iRST = 1'b0;
    endtask

    initial begin
        logic [9:0] v;
        int         b0, b1, sel;
        iRST = 1'b1;
        iKEY = 10'h3FF;
        repeat (2) @(posedge clk);
        #1;
        iRST = 1'b0;
        hold(10'h3FF, 12);
        hold(10'h000, 4);
        // clean press and release
        hold(10'h008, 20);
        hold(10'h000, 12);
        // bounce then settle
        for (int i = 0; i < 3; i++) begin
            hold(10'h004, 2);
            hold(10'h000, 2);
        end
        hold(10'h004, 15);
        hold(10'h000, 12);
        // two keys never accepted
        hold(10'h003, 20);
        hold(10'h000, 8);
        // release glitch
        hold(10'h200, 12);
        hold(10'h000, 2);
        hold(10'h200, 12);
        // second key added while held
        hold(10'h240, 12);
        hold(10'h040, 12);
        hold(10'h000, 10);
        // reset while held
        hold(10'h010, 12);
        iKEY = 10'h010;
        pulseReset();
        hold(10'h010, 12);
        hold(10'h000, 10);
        // randomized segments
        for (int seg = 0; seg < 400; seg++) begin
            sel = $urandom_range(5, 0);
            case (sel)
                0: v = 10'h000;
                1: v = lastOneHot;
                2: begin
                    v = 10'd1 << $urandom_range(9, 0);
                    lastOneHot = v;
                end
                3: begin
                    b0 = $urandom_range(9, 0);
                    b1 = (b0 + $urandom_range(9, 1)) % 10;
                    v = (10'd1 << b0) | (10'd1 << b1);
                end
                4: v = lastOneHot | (10'd1 << $urandom_range(9, 0));
                default: v = 10'($urandom);
            endcase
            if ($urandom_range(39, 0) == 0) begin
                iKEY = v;
                pulseReset();
            end
            hold(v, (sel == 1 || sel == 2) ? $urandom_range(12, 1) : $urandom_range(7, 1));
        end
        hold(10'h000, 12);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 10'(expQ.size()), 10'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
